// File: rtl/pe_issue_stage_if.sv
// Instruction stream channel into the PE issue stage: valid/ready handshake
// carrying opcode and source/destination register addresses.
interface pe_issue_stage_if #(
    parameter int OPCODE_L   = 3,
    parameter int REG_ADDR_L = 4
);
    logic                  valid;
    logic                  ready;
    logic [OPCODE_L-1:0]   opcode;
    logic [REG_ADDR_L-1:0] src0;
    logic [REG_ADDR_L-1:0] src1;
    logic [REG_ADDR_L-1:0] dst;

    modport master (
        output valid, opcode, src0, src1, dst,
        input  ready
    );

    modport slave (
        input  valid, opcode, src0, src1, dst,
        output ready
    );
endinterface

// File: rtl/pe_issue_stage.sv
// Issue and writeback stage feeding pe_operator: regfile read with full
// forwarding, registered operator inputs, one-deep writeback register.
package pe_pkg;
    localparam int DATA_L   = 16;
    localparam int OPCODE_L = 3;

    typedef enum logic [OPCODE_L-1:0] {
        SUM_OPCODE  = 3'd0,
        PROD_OPCODE = 3'd1,
        PASS_OPCODE = 3'd2,
        MAX_OPCODE  = 3'd3,
        MIN_OPCODE  = 3'd4
    } opcode_e;
endpackage

module pe_issue_stage #(
    parameter int DATA_L     = pe_pkg::DATA_L,
    parameter int OPCODE_L   = pe_pkg::OPCODE_L,
    parameter int REG_N      = 16,
    parameter int REG_ADDR_L = $clog2(REG_N)
) (
    input  logic                  clk,
    input  logic                  rst,
    pe_issue_stage_if.slave       instr,
    output logic [DATA_L-1:0]     op_in_0,
    output logic [DATA_L-1:0]     op_in_1,
    output logic [OPCODE_L-1:0]   op_opcode,
    input  logic [DATA_L-1:0]     op_out,
    input  logic                  ext_wr_en,
    input  logic [REG_ADDR_L-1:0] ext_wr_addr,
    input  logic [DATA_L-1:0]     ext_wr_data,
    input  logic [REG_ADDR_L-1:0] rd_addr,
    output logic [DATA_L-1:0]     rd_data,
    output logic                  wb_valid,
    output logic [REG_ADDR_L-1:0] wb_dst,
    output logic [DATA_L-1:0]     wb_data,
    output logic                  busy,
    output logic                  ext_err
);
    localparam logic [OPCODE_L-1:0] PASS_OP = OPCODE_L'(pe_pkg::PASS_OPCODE);

    logic [DATA_L-1:0]     regs [REG_N];
    logic                  iss_valid;
    logic [REG_ADDR_L-1:0] iss_dst;
    logic [DATA_L-1:0]     fwd_0;
    logic [DATA_L-1:0]     fwd_1;
    logic                  accept;
    logic                  ext_wr_ok;

    assign instr.ready = ~ext_wr_en;
    assign accept      = instr.valid & ~ext_wr_en;
    assign busy        = iss_valid | wb_valid;
    assign ext_wr_ok   = ext_wr_en & ~busy;
    assign rd_data     = regs[rd_addr];

    // The issue-stage result is youngest, so it is applied last and wins over wb.
    always_comb begin
        fwd_0 = regs[instr.src0];
        if (wb_valid && wb_dst == instr.src0) fwd_0 = wb_data;
        if (iss_valid && iss_dst == instr.src0) fwd_0 = op_out;

        fwd_1 = regs[instr.src1];
        if (wb_valid && wb_dst == instr.src1) fwd_1 = wb_data;
        if (iss_valid && iss_dst == instr.src1) fwd_1 = op_out;
    end

    // NOTE: non-blocking assignments throughout, so every stage samples the
    // values its predecessor held before this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_valid <= 1'b0;
            iss_dst   <= '0;
            op_in_0   <= '0;
            op_in_1   <= '0;
            op_opcode <= PASS_OP;
            wb_valid  <= 1'b0;
            wb_dst    <= '0;
            wb_data   <= '0;
            ext_err   <= 1'b0;
        end else begin
            iss_valid <= accept;
            if (accept) begin
                op_in_0   <= fwd_0;
                op_in_1   <= fwd_1;
                op_opcode <= instr.opcode;
                iss_dst   <= instr.dst;
            end else begin
                op_in_0   <= '0;
                op_in_1   <= '0;
                op_opcode <= PASS_OP;
            end

            wb_valid <= iss_valid;
            if (iss_valid) begin
                wb_data <= op_out;
                wb_dst  <= iss_dst;
            end

            if (ext_wr_en && busy) ext_err <= 1'b1;
        end
    end

    // NOTE: the register file sits in its own reset branch on purpose: software
    // relies on every entry reading zero after reset, so it cannot be a plain RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_N; i++) regs[i] <= '0;
        end else if (wb_valid) begin
            regs[wb_dst] <= wb_data;
        end else if (ext_wr_ok) begin
            regs[ext_wr_addr] <= ext_wr_data;
        end
    end
endmodule

// File: tb/tb_pe_issue_stage.sv
// Self-checking bench for pe_issue_stage: directed scenarios plus a randomized
// run against an architectural (in-order, instantly-updated) register model.
`timescale 1ns/1ps
module tb_pe_issue_stage;
    import pe_pkg::*;

    localparam int DL = pe_pkg::DATA_L;
    localparam int OL = pe_pkg::OPCODE_L;
    localparam int RN = 16;
    localparam int AL = $clog2(RN);
    localparam logic [OL-1:0] PASS_OP = OL'(PASS_OPCODE);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DL-1:0] op_in_0, op_in_1, op_out, wb_data, rd_data, ext_wr_data;
    logic [OL-1:0] op_opcode;
    logic [AL-1:0] ext_wr_addr, rd_addr, wb_dst;
    logic          ext_wr_en, wb_valid, busy, ext_err;

    int checks   = 0;
    int failures = 0;

    always #50 clk = ~clk;

    pe_issue_stage_if #(.OPCODE_L(OL), .REG_ADDR_L(AL)) instr ();

    pe_issue_stage dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr.slave),
        .op_in_0     (op_in_0),
        .op_in_1     (op_in_1),
        .op_opcode   (op_opcode),
        .op_out      (op_out),
        .ext_wr_en   (ext_wr_en),
        .ext_wr_addr (ext_wr_addr),
        .ext_wr_data (ext_wr_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .wb_valid    (wb_valid),
        .wb_dst      (wb_dst),
        .wb_data     (wb_data),
        .busy        (busy),
        .ext_err     (ext_err)
    );

    function automatic logic [DL-1:0] op_fn(input logic [OL-1:0] op,
                                            input logic [DL-1:0] a,
                                            input logic [DL-1:0] b);
        logic [DL-1:0] r;
        r = '0;
        if (op == SUM_OPCODE)  r = a + b;
        if (op == PROD_OPCODE) r = a * b;
        if (op == PASS_OPCODE) r = a;
        if (op == MAX_OPCODE)  r = (a > b) ? a : b;
        if (op == MIN_OPCODE)  r = (a < b) ? a : b;
        return r;
    endfunction

    // Stand-in for pe_operator.
    assign op_out = op_fn(op_opcode, op_in_0, op_in_1);

    // Architectural model: registers update the moment an instruction is accepted.
    typedef struct packed {
        logic          v;
        logic [OL-1:0] op;
        logic [DL-1:0] a;
        logic [DL-1:0] b;
        logic [DL-1:0] r;
        logic [AL-1:0] dst;
    } stage_t;

    logic [DL-1:0] m_regs [RN];
    stage_t        s1, s2;
    logic          m_err;

    task automatic model_reset();
        for (int i = 0; i < RN; i++) m_regs[i] = '0;
        s1    = '0;
        s1.op = PASS_OP;
        s2    = s1;
        m_err = 1'b0;
    endtask

    // Drive one cycle of inputs from a negedge, advance the model, return at the next negedge.
    task automatic step(input logic v, input logic [OL-1:0] op,
                        input logic [AL-1:0] a0, input logic [AL-1:0] a1, input logic [AL-1:0] d,
                        input logic ew, input logic [AL-1:0] ea, input logic [DL-1:0] ed,
                        output logic rdy);
        logic busy_m, acc;
        instr.valid  = v;
        instr.opcode = op;
        instr.src0   = a0;
        instr.src1   = a1;
        instr.dst    = d;
        ext_wr_en    = ew;
        ext_wr_addr  = ea;
        ext_wr_data  = ed;
        #1 rdy = instr.ready;

        busy_m = s1.v | s2.v;
        acc    = v & ~ew;
        if (ew) begin
            if (busy_m) m_err = 1'b1;
            else        m_regs[ea] = ed;
        end
        s2    = s1;
        s1    = '0;
        s1.op = PASS_OP;
        if (acc) begin
            s1.v   = 1'b1;
            s1.op  = op;
            s1.a   = m_regs[a0];
            s1.b   = m_regs[a1];
            s1.r   = op_fn(op, s1.a, s1.b);
            s1.dst = d;
            m_regs[d] = s1.r;
        end

        @(negedge clk);
        instr.valid = 1'b0;
        ext_wr_en   = 1'b0;
    endtask

    task automatic idle(input int n);
        logic rdy;
        for (int i = 0; i < n; i++) step(1'b0, PASS_OP, '0, '0, '0, 1'b0, '0, '0, rdy);
    endtask

    task automatic rd(input logic [AL-1:0] a, output logic [DL-1:0] d);
        rd_addr = a;
        #1 d = rd_data;
    endtask

    task automatic test_reset();
        logic [DL-1:0] d;
        @(negedge clk);
        checks++;
        if ({wb_valid, busy, ext_err} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: wb_valid/busy/ext_err=%b expected 000", {wb_valid, busy, ext_err});
        end
        checks++;
        if ({op_in_0, op_in_1, op_opcode, wb_dst, wb_data} !== {{(2*DL){1'b0}}, PASS_OP, {AL{1'b0}}, {DL{1'b0}}}) begin
            failures++;
            $display("FAIL reset_regs: op_in_0=%h op_in_1=%h op_opcode=%h wb_dst=%h wb_data=%h expected 0/0/%h/0/0",
                     op_in_0, op_in_1, op_opcode, wb_dst, wb_data, PASS_OP);
        end
        for (int i = 0; i < RN; i++) begin
            rd(AL'(i), d);
            checks++;
            if (d !== '0) begin
                failures++;
                $display("FAIL reset_regfile r%0d: got %h expected 0", i, d);
            end
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ext_load();
        logic rdy;
        logic [DL-1:0] d;
        step(1'b0, PASS_OP, '0, '0, '0, 1'b1, 4'd1, 16'h0011, rdy);
        checks++;
        if (rdy !== 1'b0) begin
            failures++;
            $display("FAIL ext_ready: instr_ready=%b expected 0", rdy);
        end
        step(1'b0, PASS_OP, '0, '0, '0, 1'b1, 4'd2, 16'h0022, rdy);
        rd(4'd1, d);
        checks++;
        if (d !== 16'h0011) begin failures++; $display("FAIL ext_load r1: got %h expected 0011", d); end
        rd(4'd2, d);
        checks++;
        if (d !== 16'h0022) begin failures++; $display("FAIL ext_load r2: got %h expected 0022", d); end
        checks++;
        if ({busy, ext_err} !== 2'b00) begin
            failures++;
            $display("FAIL ext_load_flags: busy/ext_err=%b expected 00", {busy, ext_err});
        end
    endtask

    task automatic test_single_pass();
        logic rdy;
        logic [DL-1:0] d;
        step(1'b1, PASS_OP, 4'd1, 4'd2, 4'd3, 1'b0, '0, '0, rdy);
        checks++;
        if ({op_in_0, op_opcode, busy} !== {16'h0011, PASS_OP, 1'b1}) begin
            failures++;
            $display("FAIL pass_issue: op_in_0=%h op_opcode=%h busy=%b expected 0011/%h/1", op_in_0, op_opcode, busy, PASS_OP);
        end
        idle(1);
        checks++;
        if ({wb_valid, wb_dst, wb_data} !== {1'b1, 4'd3, 16'h0011}) begin
            failures++;
            $display("FAIL pass_wb: valid=%b dst=%h data=%h expected 1/3/0011", wb_valid, wb_dst, wb_data);
        end
        idle(1);
        rd(4'd3, d);
        checks++;
        if ({busy, d} !== {1'b0, 16'h0011}) begin
            failures++;
            $display("FAIL pass_commit: busy=%b r3=%h expected 0/0011", busy, d);
        end
    endtask

    task automatic test_back_to_back();
        logic rdy;
        logic [DL-1:0] d;
        step(1'b1, OL'(MAX_OPCODE), 4'd1, 4'd2, 4'd4, 1'b0, '0, '0, rdy);
        step(1'b1, PASS_OP, 4'd4, 4'd0, 4'd5, 1'b0, '0, '0, rdy);
        checks++;
        if ({op_in_0, op_in_1} !== {16'h0022, 16'h0000}) begin
            failures++;
            $display("FAIL b2b_opout_fwd: op_in_0=%h op_in_1=%h expected 0022/0000", op_in_0, op_in_1);
        end
        step(1'b1, OL'(MIN_OPCODE), 4'd4, 4'd1, 4'd6, 1'b0, '0, '0, rdy);
        checks++;
        if ({op_in_0, op_in_1} !== {16'h0022, 16'h0011}) begin
            failures++;
            $display("FAIL b2b_wb_fwd: op_in_0=%h op_in_1=%h expected 0022/0011", op_in_0, op_in_1);
        end
        idle(3);
        rd(4'd5, d);
        checks++;
        if (d !== 16'h0022) begin failures++; $display("FAIL b2b r5: got %h expected 0022", d); end
        rd(4'd6, d);
        checks++;
        if (d !== 16'h0011) begin failures++; $display("FAIL b2b r6: got %h expected 0011", d); end
    endtask

    task automatic test_priority();
        logic rdy;
        logic [DL-1:0] d;
        step(1'b1, PASS_OP, 4'd1, 4'd0, 4'd7, 1'b0, '0, '0, rdy);
        step(1'b1, PASS_OP, 4'd2, 4'd0, 4'd7, 1'b0, '0, '0, rdy);
        step(1'b1, OL'(MAX_OPCODE), 4'd7, 4'd7, 4'd8, 1'b0, '0, '0, rdy);
        checks++;
        if ({op_in_0, op_in_1} !== {16'h0022, 16'h0022}) begin
            failures++;
            $display("FAIL prio_same_src: op_in_0=%h op_in_1=%h expected 0022/0022", op_in_0, op_in_1);
        end
        idle(3);
        rd(4'd8, d);
        checks++;
        if (d !== 16'h0022) begin failures++; $display("FAIL prio r8: got %h expected 0022", d); end
    endtask

    task automatic test_ext_busy();
        logic rdy;
        logic [DL-1:0] d;
        step(1'b1, PASS_OP, 4'd1, 4'd1, 4'd10, 1'b0, '0, '0, rdy);
        step(1'b1, PASS_OP, 4'd2, 4'd2, 4'd11, 1'b1, 4'd9, 16'h0099, rdy);
        checks++;
        if (rdy !== 1'b0) begin failures++; $display("FAIL busy_ready: instr_ready=%b expected 0", rdy); end
        checks++;
        if (ext_err !== 1'b1) begin failures++; $display("FAIL busy_err_set: ext_err=%b expected 1", ext_err); end
        idle(4);
        rd(4'd9, d);
        checks++;
        if (d !== 16'h0000) begin failures++; $display("FAIL busy_drop r9: got %h expected 0000", d); end
        rd(4'd11, d);
        checks++;
        if (d !== 16'h0000) begin failures++; $display("FAIL busy_noaccept r11: got %h expected 0000", d); end
        checks++;
        if (ext_err !== 1'b1) begin failures++; $display("FAIL busy_err_sticky: ext_err=%b expected 1", ext_err); end
    endtask

    task automatic test_reset_mid_run();
        logic rdy;
        logic [DL-1:0] d;
        step(1'b1, PASS_OP, 4'd1, 4'd1, 4'd3, 1'b0, '0, '0, rdy);
        idle(1);
        checks++;
        if ({wb_valid, wb_dst} !== {1'b1, 4'd3}) begin
            failures++;
            $display("FAIL midrst_pre: wb_valid=%b wb_dst=%h expected 1/3", wb_valid, wb_dst);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({wb_valid, op_opcode, ext_err} !== {1'b0, PASS_OP, 1'b0}) begin
            failures++;
            $display("FAIL midrst_now: wb_valid=%b op_opcode=%h ext_err=%b expected 0/%h/0", wb_valid, op_opcode, ext_err, PASS_OP);
        end
        for (int i = 0; i < RN; i++) begin
            rd(AL'(i), d);
            checks++;
            if (d !== '0) begin failures++; $display("FAIL midrst_regfile r%0d: got %h expected 0", i, d); end
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        idle(3);
        rd(4'd3, d);
        checks++;
        if (d !== '0) begin failures++; $display("FAIL midrst_after r3: got %h expected 0", d); end
    endtask

    task automatic test_random();
        logic rdy;
        logic [DL-1:0] d;
        logic [OL-1:0] ops [5];
        ops[0] = OL'(SUM_OPCODE);
        ops[1] = OL'(PROD_OPCODE);
        ops[2] = OL'(PASS_OPCODE);
        ops[3] = OL'(MAX_OPCODE);
        ops[4] = OL'(MIN_OPCODE);
        for (int i = 0; i < 500; i++) begin
            checks++;
            if ({op_in_0, op_in_1, op_opcode} !== {s1.a, s1.b, s1.op}) begin
                failures++;
                $display("FAIL rnd_issue c%0d: in0=%h in1=%h op=%h expected %h/%h/%h",
                         i, op_in_0, op_in_1, op_opcode, s1.a, s1.b, s1.op);
            end
            checks++;
            if (wb_valid !== s2.v || (s2.v && {wb_dst, wb_data} !== {s2.dst, s2.r})) begin
                failures++;
                $display("FAIL rnd_wb c%0d: valid=%b dst=%h data=%h expected %b/%h/%h",
                         i, wb_valid, wb_dst, wb_data, s2.v, s2.dst, s2.r);
            end
            checks++;
            if ({busy, ext_err} !== {s1.v | s2.v, m_err}) begin
                failures++;
                $display("FAIL rnd_flags c%0d: busy/ext_err=%b expected %b", i, {busy, ext_err}, {s1.v | s2.v, m_err});
            end
            step($urandom_range(0, 9) < 6, ops[$urandom_range(0, 4)],
                 AL'($urandom), AL'($urandom), AL'($urandom),
                 $urandom_range(0, 9) < 2, AL'($urandom), DL'($urandom), rdy);
        end
        idle(3);
        for (int i = 0; i < RN; i++) begin
            rd(AL'(i), d);
            checks++;
            if (d !== m_regs[i]) begin
                failures++;
                $display("FAIL rnd_final r%0d: got %h expected %h", i, d, m_regs[i]);
            end
        end
    endtask

    initial begin
        instr.valid  = 1'b0;
        instr.opcode = PASS_OP;
        instr.src0   = '0;
        instr.src1   = '0;
        instr.dst    = '0;
        ext_wr_en    = 1'b0;
        ext_wr_addr  = '0;
        ext_wr_data  = '0;
        rd_addr      = '0;
        model_reset();

        test_reset();
        test_ext_load();
        test_single_pass();
        test_back_to_back();
        test_priority();
        test_ext_busy();
        test_reset_mid_run();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
